// File: rtl/countone_mul_pkg.sv
// Shared definitions for the round-robin multiplier front-end.
// Holds the datapath widths, the pipeline tag type and a small
// index wrap helper used by the arbiter.
package countone_mul_pkg;

    localparam int OP_W    = 12;
    localparam int PROD_W  = 24;
    localparam int ID_W    = 3;
    localparam int MAX_REQ = 8;
    localparam int CNT_W   = 4;
    localparam int IW1     = ID_W + 1;

    // One entry of the tag pipeline that shadows the external multiplier.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Reduce sum (which is always < 2*n) modulo n.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [IW1-1:0] sum,
                                                 input logic [IW1-1:0] n);
        logic [IW1-1:0] r;
        r = (sum >= n) ? (sum - n) : sum;
        return r[ID_W-1:0];
    endfunction

endpackage

// File: rtl/countone_rr_arb.sv
// Round-robin arbiter: combinational grant search starting at rr_ptr,
// plus the rr_ptr register that moves past the winner on each transfer.
module countone_rr_arb
    import countone_mul_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               advance,
    output logic               grant_any,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [MAX_REQ-1:0] valid_ext;
    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Pad to the maximum width so a 3-bit index never runs off the vector.
    assign valid_ext = MAX_REQ'(req_valid);

    // Candidate gi is the requester gi positions after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = wrap_idx({1'b0, rr_ptr_q} + IW1'(gi), IW1'(NUM_REQ));
            assign cand_hit[gi] = valid_ext[cand_idx[gi]];
        end
    endgenerate

    // Closest asserted candidate to the pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx[i];
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && grant_any) begin
            rr_ptr_d = wrap_idx({1'b0, grant_idx} + IW1'(1), IW1'(NUM_REQ));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/countone_mul_arb.sv
// Shares one external pipelined multiplier between NUM_REQ requesters.
// A tag pipeline of depth LATENCY tracks which requester owns each product
// and freezes together with the multiplier while a response is stalled.
// Optional statistics outputs are enabled by defining COUNTONE_MUL_ARB_STATS_EN.
module countone_mul_arb
    import countone_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic                    mul_ce,
    output logic [OP_W-1:0]         mul_din0,
    output logic [OP_W-1:0]         mul_din1,
    input  logic [PROD_W-1:0]       mul_dout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [PROD_W-1:0]       rsp_p,
    output logic [CNT_W-1:0]        inflight
`ifdef COUNTONE_MUL_ARB_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_stall
`endif
);

    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic            xfer;
    logic [OP_W-1:0] op_a [MAX_REQ];
    logic [OP_W-1:0] op_b [MAX_REQ];
    logic [OP_W-1:0] din0_q, din0_d;
    logic [OP_W-1:0] din1_q, din1_d;
    tag_t            tag_q [LATENCY];
    tag_t            tag_d [LATENCY];
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic            rsp_fire;

    countone_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .advance   (xfer),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    // Unpack operands; unused slots read as zero so any 3-bit index is safe.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_ops
            if (gi < NUM_REQ) begin : g_live
                assign op_a[gi] = req_a[gi*OP_W +: OP_W];
                assign op_b[gi] = req_b[gi*OP_W +: OP_W];
            end else begin : g_pad
                assign op_a[gi] = '0;
                assign op_b[gi] = '0;
            end
        end
    endgenerate

    assign rsp_valid = tag_q[LATENCY-1].valid;
    assign rsp_id    = tag_q[LATENCY-1].id;
    assign rsp_p     = mul_dout;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign mul_ce    = !(rsp_valid && !rsp_ready);
    // Ready is suppressed during reset so nothing can be accepted then.
    assign xfer      = reset_n && grant_any && mul_ce;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = xfer && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Operands follow the winner on a transfer and hold otherwise.
    always_comb begin
        din0_d = din0_q;
        din1_d = din1_q;
        if (xfer) begin
            din0_d = op_a[grant_idx];
            din1_d = op_b[grant_idx];
        end
    end

    assign mul_din0 = din0_d;
    assign mul_din1 = din1_d;

    // Tag pipeline shifts in lockstep with the multiplier clock enable.
    always_comb begin
        tag_d = tag_q;
        if (mul_ce) begin
            tag_d[0].valid = xfer;
            tag_d[0].id    = xfer ? grant_idx : '0;
            for (int i = 1; i < LATENCY; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    // Outstanding-request counter; simultaneous issue and retire cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({xfer, rsp_fire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    assign inflight = inflight_q;

    // Datapath and tag state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din0_q     <= '0;
            din1_q     <= '0;
            inflight_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            din0_q     <= din0_d;
            din1_q     <= din1_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

`ifdef COUNTONE_MUL_ARB_STATS_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stall_q,  stall_d;

    // Saturating event counters for issued transfers and frozen cycles.
    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (xfer && (issued_q != '1)) begin
            issued_d = issued_q + 32'd1;
        end
        if (!mul_ce && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_countone_mul_arb.sv
// Directed bench for countone_mul_arb with a behavioural LATENCY-stage
// multiplier. Statistics checks are compiled when COUNTONE_MUL_ARB_STATS_EN
// is defined.
module tb_countone_mul_arb;
    import countone_mul_pkg::*;

    localparam int NR  = 4;
    localparam int LAT = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*OP_W-1:0] req_a;
    logic [NR*OP_W-1:0] req_b;
    logic               mul_ce;
    logic [OP_W-1:0]    mul_din0;
    logic [OP_W-1:0]    mul_din1;
    logic [PROD_W-1:0]  mul_dout;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [PROD_W-1:0]  rsp_p;
    logic [CNT_W-1:0]   inflight;
`ifdef COUNTONE_MUL_ARB_STATS_EN
    logic [31:0]        stat_issued;
    logic [31:0]        stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int x_idx [$];
    int x_cyc [$];
    int r_id  [$];
    int r_p   [$];
    int r_cyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    countone_mul_arb #(
        .NUM_REQ (NR),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .inflight  (inflight)
`ifdef COUNTONE_MUL_ARB_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    // Behavioural multiplier: LAT ce-enabled edges from din to dout.
    logic [PROD_W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= mul_din0 * mul_din1;
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_dout = mpipe[LAT-1];

    // Transaction monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    x_idx.push_back(i);
                    x_cyc.push_back(cyc);
                    $display("[%0d] issue req=%0d a=%0h b=%0h", cyc, i, mul_din0, mul_din1);
                end
            end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id));
                r_p.push_back(int'(rsp_p));
                r_cyc.push_back(cyc);
                $display("[%0d] response id=%0d p=%0h", cyc, rsp_id, rsp_p);
            end
        end
    end

    task automatic clear_mon();
        x_idx.delete(); x_cyc.delete();
        r_id.delete(); r_p.delete(); r_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rsp_ready = 1'b1;
        req_valid = '1; req_a = '1; req_b = '1;
        @(negedge clk); @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (mul_din0 !== 12'h000 || mul_din1 !== 12'h000) begin errors++; $display("FAIL reset_din: got %h/%h expected 000/000", mul_din0, mul_din1); end
        @(posedge clk); #1;
        req_valid = '0; req_a = '0; req_b = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        clear_mon();
        @(posedge clk); #1;
        req_valid = 4'b0100; req_a[24 +: 12] = 12'hFFF; req_b[24 +: 12] = 12'hFFF;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        checks++; if (mul_din0 !== 12'hFFF || mul_din1 !== 12'hFFF) begin errors++; $display("FAIL single_din: got %h/%h expected fff/fff", mul_din0, mul_din1); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        checks++; if (r_id.size() != 1 || x_cyc.size() != 1) begin errors++; $display("FAIL single_count: got %0d responses %0d issues expected 1/1", r_id.size(), x_cyc.size()); end
        else begin
            checks++; if (r_id[0] != 2) begin errors++; $display("FAIL single_id: got %0d expected 2", r_id[0]); end
            checks++; if (r_p[0] != 24'hFFE001) begin errors++; $display("FAIL single_p: got %h expected ffe001", r_p[0]); end
            checks++; if (r_cyc[0] - x_cyc[0] != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", r_cyc[0] - x_cyc[0], LAT); end
        end
    endtask

    task automatic test_all_valid();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        int exp_p [5] = '{10, 20, 30, 40, 10};
        do_reset();
        clear_mon();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'b1;
            req_a[i*12 +: 12] = 12'(i + 1);
            req_b[i*12 +: 12] = 12'd10;
        end
        repeat (5) @(posedge clk); #1;
        req_valid = '0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        checks++; if (x_idx.size() != 5 || r_p.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d issues %0d responses expected 5/5", x_idx.size(), r_p.size()); end
        else begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (x_idx[k] != exp_g[k]) begin errors++; $display("FAIL b2b_grant%0d: got %0d expected %0d", k, x_idx[k], exp_g[k]); end
                checks++; if (r_id[k] != exp_g[k] || r_p[k] != exp_p[k]) begin errors++; $display("FAIL b2b_rsp%0d: got id %0d p %0d expected id %0d p %0d", k, r_id[k], r_p[k], exp_g[k], exp_p[k]); end
                if (k > 0) begin
                    checks++; if (x_cyc[k] - x_cyc[k-1] != 1) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 1", k, x_cyc[k] - x_cyc[k-1]); end
                end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_g [3] = '{3, 1, 3};
        int exp_p [3] = '{99, 35, 99};
        // Pointer is 1 here; one grant to requester 1 moves it to 2.
        @(posedge clk); #1;
        req_valid = 4'b0010; req_a[12 +: 12] = 12'd5; req_b[12 +: 12] = 12'd7;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (LAT + 2) @(posedge clk); #1;
        clear_mon();
        req_valid = 4'b1010; req_a[36 +: 12] = 12'd9; req_b[36 +: 12] = 12'd11;
        repeat (3) @(posedge clk); #1;
        req_valid = '0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        checks++; if (x_idx.size() != 3 || r_p.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d issues %0d responses expected 3/3", x_idx.size(), r_p.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (x_idx[k] != exp_g[k]) begin errors++; $display("FAIL wrap_grant%0d: got %0d expected %0d", k, x_idx[k], exp_g[k]); end
                checks++; if (r_id[k] != exp_g[k] || r_p[k] != exp_p[k]) begin errors++; $display("FAIL wrap_rsp%0d: got id %0d p %0d expected id %0d p %0d", k, r_id[k], r_p[k], exp_g[k], exp_p[k]); end
            end
        end
    endtask

    task automatic test_stall();
        int exp_p [4] = '{200, 300, 400, 500};
        clear_mon();
        @(posedge clk); #1;
        req_valid = 4'b0001; req_a[0 +: 12] = 12'd2; req_b[0 +: 12] = 12'd100;
        @(posedge clk); #1; req_a[0 +: 12] = 12'd3;
        @(posedge clk); #1; req_a[0 +: 12] = 12'd4;
        @(posedge clk); #1; req_a[0 +: 12] = 12'd5; rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_p !== 24'd200) begin errors++; $display("FAIL stall_rsp%0d: got v %b id %0d p %0d expected v 1 id 0 p 200", k, rsp_valid, rsp_id, rsp_p); end
            checks++; if (req_ready !== 4'b0000 || mul_ce !== 1'b0) begin errors++; $display("FAIL stall_ctrl%0d: got ready %b ce %b expected 0000/0", k, req_ready, mul_ce); end
            checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL stall_inflight%0d: got %0d expected 3", k, inflight); end
            if (k < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; req_valid = '0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        checks++; if (r_p.size() != 4 || x_idx.size() != 4) begin errors++; $display("FAIL stall_count: got %0d responses %0d issues expected 4/4", r_p.size(), x_idx.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (r_p[k] != exp_p[k] || r_id[k] != 0) begin errors++; $display("FAIL stall_order%0d: got id %0d p %0d expected id 0 p %0d", k, r_id[k], r_p[k], exp_p[k]); end
            end
        end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL stall_drain: got %0d expected 0", inflight); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            req_valid = 4'b0001; req_a[0 +: 12] = 12'(k + 1); req_b[0 +: 12] = 12'd1;
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++; if (inflight !== 4'd3 || rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got inflight %0d v %b expected 3/1", inflight, rsp_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || inflight !== 4'd0) begin errors++; $display("FAIL mid_reset: got v %b id %0d inflight %0d expected 0/0/0", rsp_valid, rsp_id, inflight); end
        checks++; if (mul_din0 !== 12'h000 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_din: got din0 %h ready %b expected 000/0000", mul_din0, req_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_mon();
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        checks++; if (r_id.size() != 0) begin errors++; $display("FAIL mid_ghost: got %0d responses expected 0", r_id.size()); end
    endtask

`ifdef COUNTONE_MUL_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        clear_mon();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            req_valid = 4'b0001; req_a[0 +: 12] = 12'(k + 1); req_b[0 +: 12] = 12'd1;
        end
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        rsp_ready = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        @(negedge clk);
        checks++; if (stat_issued !== 32'd6) begin errors++; $display("FAIL stat_issued: got %0d expected 6", stat_issued); end
        checks++; if (stat_stall !== 32'd5) begin errors++; $display("FAIL stat_stall: got %0d expected 5", stat_stall); end
        checks++; if (r_p.size() != 6) begin errors++; $display("FAIL stat_rsp_count: got %0d expected 6", r_p.size()); end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_all_valid();
        test_wrap();
        test_stall();
        test_reset_mid();
`ifdef COUNTONE_MUL_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
